// File: rtl/sbox_unmsk_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sbox_unmsk_pipe
//
// Receiving end of the 4-share remasking interface around the PRINCE S-box.
// Each input beat carries four 8-bit shares plus the 12-bit randomness that
// was used to remask them. The block strips the per-share remask, recombines
// the shares into the plain byte and streams it out over valid/ready. It
// frames every BYTES_PER_STATE output bytes with out_last.
//
// Recombination is split over two register stages. Stage 1 folds shares
// 1+2 and shares 3+4 into separate registers. Stage 2 folds those two
// partial sums. As a result, no single combinational cone ever sees all
// four shares at once.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   input beat valid
//   in_ready   out  1   input beat can be accepted this cycle
//   in1..in4   in   8   masked shares
//   in_rand    in   12  remask randomness r1=[2:0] r2=[5:3] r3=[8:6] r4=[11:9]
//   out_valid  out  1   out_data valid
//   out_ready  in   1   downstream accepts the output beat
//   out_data   out  8   unmasked byte
//   out_last   out  1   last byte of a PRINCE state (qualified by out_valid)
// ---------------------------------------------------------------------------
module sbox_unmsk_pipe #(
    parameter int BYTES_PER_STATE = 8,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic [7:0]  in4,
    input  logic [11:0] in_rand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_STATE - 1);

    // Remask pattern: r in bits 6:4, r bit-reversed in bits 3:1, edges zero.
    function automatic logic [7:0] mask_byte(input logic [2:0] r);
        return {1'b0, r, r[0], r[1], r[2], 1'b0};
    endfunction

    function automatic logic [7:0] unmask_share(input logic [7:0] s, input logic [2:0] r);
        return s ^ mask_byte(r);
    endfunction

    // Stage 1: partial sums of the unmasked share pairs.
    logic [7:0]       p12_q, p12_d;
    logic [7:0]       p34_q, p34_d;
    logic             v1_q,  v1_d;
    // Stage 2: recombined byte.
    logic [7:0]       data_q, data_d;
    logic             v2_q,   v2_d;
    // Output byte position within the current state.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic adv1;
    logic in_hs;
    logic out_hs;
    logic in_ready_int;

    // Stage 1 drains when stage 2 is empty or is being emptied this cycle.
    // This makes in_ready depend combinationally on out_ready, so the
    // pipeline sustains one byte per cycle with only two registers.
    always_comb begin
        adv1         = v1_q && (!v2_q || out_ready);
        in_ready_int = !rst && (!v1_q || adv1);
        in_hs        = in_valid && in_ready_int;
        out_hs       = !rst && v2_q && out_ready;
    end

    always_comb begin
        p12_d  = p12_q;
        p34_d  = p34_q;
        v1_d   = v1_q;
        data_d = data_q;
        v2_d   = v2_q;
        cnt_d  = cnt_q;

        if (in_hs) begin
            p12_d = unmask_share(in1, in_rand[2:0]) ^ unmask_share(in2, in_rand[5:3]);
            p34_d = unmask_share(in3, in_rand[8:6]) ^ unmask_share(in4, in_rand[11:9]);
            v1_d  = 1'b1;
        end else if (adv1) begin
            v1_d  = 1'b0;
        end

        if (adv1) begin
            data_d = p12_q ^ p34_q;
            v2_d   = 1'b1;
        end else if (out_ready) begin
            v2_d   = 1'b0;
        end

        if (out_hs) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p12_q  <= '0;
            p34_q  <= '0;
            v1_q   <= 1'b0;
            data_q <= '0;
            v2_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            p12_q  <= p12_d;
            p34_q  <= p34_d;
            v1_q   <= v1_d;
            data_q <= data_d;
            v2_q   <= v2_d;
            cnt_q  <= cnt_d;
        end
    end

    // Outputs are forced idle while rst is high so that nothing handshakes
    // in the reset cycle, even though the registers only clear at its end.
    always_comb begin
        in_ready  = in_ready_int;
        out_valid = !rst && v2_q;
        out_last  = !rst && v2_q && (cnt_q == LAST_CNT);
        out_data  = rst ? 8'h00 : data_q;
    end

endmodule
